// File: rtl/lag_meter_if.sv
// Raster, flash-box and measurement signals between a timing generator/controller and lag_meter.
// Plain bundle with no flow control; every field is a level or a single-cycle pulse.
interface lag_meter_if;
    logic        ce_pixel;
    logic        hblank;
    logic        vblank;
    logic        vsync;
    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic [11:0] box_x;
    logic [11:0] box_y;
    logic [11:0] box_w;
    logic [11:0] box_h;
    logic        start;
    logic        sensor;
    logic [23:0] rgb;
    logic        busy;
    logic        done;
    logic [15:0] result_us;
    logic        timeout;

    modport master (
        output ce_pixel, hblank, vblank, vsync, hcnt, vcnt,
        output box_x, box_y, box_w, box_h, start, sensor,
        input  rgb, busy, done, result_us, timeout
    );

    modport slave (
        input  ce_pixel, hblank, vblank, vsync, hcnt, vcnt,
        input  box_x, box_y, box_w, box_h, start, sensor,
        output rgb, busy, done, result_us, timeout
    );
endinterface

// File: rtl/lag_meter.sv
// Display-to-photodiode latency meter: flashes a box, times from box origin to debounced light.
// Latency: rgb 1 clk after raster inputs, done/result registered; no backpressure (done is a pulse).
module lag_meter #(
    parameter int CLKS_PER_US     = 50,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int DEBOUNCE        = 4
) (
    input  logic        clk,
    input  logic        reset,
    lag_meter_if.slave  bus
);
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, ARM, FLASH, COOLDOWN} state_t;
    state_t state, state_nx;

    logic          sync1, sync2;
    logic [DW-1:0] run_cnt;
    logic          detect;
    logic          vsync_d, vs_rise;
    logic          timer_run;
    logic [PW-1:0] presc;
    logic [15:0]   counter;
    logic [CW-1:0] cd_cnt;
    logic          in_box, at_origin, presc_wrap, saturated, measure_end, cd_last;
    logic [23:0]   rgb_q;
    logic          done_q, timeout_q;
    logic [15:0]   result_q;

    assign detect      = (run_cnt == DW'(DEBOUNCE));
    assign vs_rise     = bus.vsync & ~vsync_d;
    // 13-bit sums so a box touching the top of the counter range does not wrap
    assign in_box      = ({1'b0, bus.hcnt} >= {1'b0, bus.box_x}) &&
                         ({1'b0, bus.hcnt} <  ({1'b0, bus.box_x} + {1'b0, bus.box_w})) &&
                         ({1'b0, bus.vcnt} >= {1'b0, bus.box_y}) &&
                         ({1'b0, bus.vcnt} <  ({1'b0, bus.box_y} + {1'b0, bus.box_h}));
    assign at_origin   = bus.ce_pixel && (bus.hcnt == bus.box_x) && (bus.vcnt == bus.box_y);
    assign presc_wrap  = (presc == PW'(CLKS_PER_US - 1));
    assign saturated   = (counter == 16'hFFFF);
    // Light seen before the timer starts is stale and never ends the measurement
    assign measure_end = (state == FLASH) && timer_run && (detect || saturated);
    assign cd_last     = (cd_cnt == CW'(COOLDOWN_FRAMES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.start) state_nx = ARM;
            ARM:      if (vs_rise) state_nx = FLASH;
            FLASH:    if (measure_end) state_nx = COOLDOWN;
            COOLDOWN: if (vs_rise && cd_last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            run_cnt <= '0;
            vsync_d <= 1'b0;
        end else begin
            sync1   <= bus.sensor;
            sync2   <= sync1;
            vsync_d <= bus.vsync;
            if (!sync2)       run_cnt <= '0;
            else if (!detect) run_cnt <= run_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_run <= 1'b0;
            presc     <= '0;
            counter   <= '0;
        end else if (state == ARM && vs_rise) begin
            timer_run <= 1'b0;
            presc     <= '0;
            counter   <= '0;
        end else if (state == FLASH) begin
            if (!timer_run) begin
                if (at_origin) timer_run <= 1'b1;
            end else if (!saturated) begin
                if (presc_wrap) begin
                    presc   <= '0;
                    counter <= counter + 16'd1;
                end else begin
                    presc   <= presc + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            cd_cnt    <= '0;
            rgb_q     <= '0;
        end else begin
            done_q <= measure_end;
            if (measure_end) begin
                result_q  <= counter;
                timeout_q <= ~detect;
            end
            if (state != COOLDOWN) cd_cnt <= '0;
            else if (vs_rise)      cd_cnt <= cd_cnt + CW'(1);
            if (bus.hblank || bus.vblank)       rgb_q <= '0;
            else if (in_box && state == FLASH)  rgb_q <= 24'hFFFFFF;
            else                                rgb_q <= '0;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.result_us = result_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_lag_meter.sv
// Bench for lag_meter: dut_a (2 clk/us) runs directed measurements, dut_b (1 clk/us) runs a full timeout.
// Expected results are queued when stimulus is driven and compared when done pulses.
module tb_lag_meter;
    localparam int HT = 20, VT = 20, HACT = 16, VACT = 16, VS_LINE = 18;
    localparam int BX = 10, BY = 10, BW = 4, BH = 4, DEB = 4;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    lag_meter_if ifa();
    lag_meter_if ifb();

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, vs_cnt = 0, last_origin = 0, bad_pix = 0, origin_cyc = 0;
    bit   a_done_seen = 0, b_done_seen = 0, sweep_on = 0, sweep_flash = 0;

    always #5 clk = ~clk;

    lag_meter #(.CLKS_PER_US(2), .COOLDOWN_FRAMES(8), .DEBOUNCE(DEB)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa.slave));
    lag_meter #(.CLKS_PER_US(1), .COOLDOWN_FRAMES(1), .DEBOUNCE(DEB)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input logic [15:0] obs, input logic [15:0] lo,
                             input logic [15:0] hi);
        checks++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic bit box_hit(input int h, input int v);
        return (h >= BX) && (h < BX + BW) && (v >= BY) && (v < BY + BH);
    endfunction

    task automatic drive_raster(input int h, input int v);
        ifa.hcnt = 12'(h);  ifb.hcnt = 12'(h);
        ifa.vcnt = 12'(v);  ifb.vcnt = 12'(v);
        ifa.hblank = (h >= HACT);  ifb.hblank = (h >= HACT);
        ifa.vblank = (v >= VACT);  ifb.vblank = (v >= VACT);
        ifa.vsync  = (v == VS_LINE);  ifb.vsync = (v == VS_LINE);
    endtask

    // One clk: sample outputs after the edge, then present the next raster position.
    task automatic step();
        exp_t e;
        int h, v;
        logic [23:0] exp_rgb;
        logic old_vs;
        @(posedge clk);
        #1;
        cyc++;
        if (ifa.done === 1'b1) begin
            a_done_seen = 1;
            chk("a_done_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk_range("a_result_us", ifa.result_us, e.lo, e.hi);
                chk("a_timeout", 32'(ifa.timeout), 32'(e.to));
            end
        end
        if (ifb.done === 1'b1) begin
            b_done_seen = 1;
            chk("b_done_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk_range("b_result_us", ifb.result_us, e.lo, e.hi);
                chk("b_timeout", 32'(ifb.timeout), 32'(e.to));
            end
        end
        h = int'(ifa.hcnt);
        v = int'(ifa.vcnt);
        if (sweep_on) begin
            exp_rgb = (!ifa.hblank && !ifa.vblank && box_hit(h, v) && sweep_flash) ? 24'hFFFFFF : 24'h0;
            if (ifa.rgb !== exp_rgb) bad_pix++;
        end
        old_vs = ifa.vsync;
        if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end else begin
            h++;
        end
        drive_raster(h, v);
        if (ifa.vsync && !old_vs) vs_cnt++;
        if (h == BX && v == BY) last_origin = cyc;
    endtask

    task automatic wait_vs(input int n);
        int target = vs_cnt + n;
        for (int i = 0; i < (n + 1) * HT * VT && vs_cnt < target; i++) step();
    endtask

    task automatic wait_row(input int r);
        for (int i = 0; i < 2 * HT * VT && !(ifa.vcnt == 12'(r) && ifa.hcnt == 12'd0); i++) step();
    endtask

    task automatic wait_origin();
        for (int i = 0; i < 2 * HT * VT && !(ifa.hcnt == 12'(BX) && ifa.vcnt == 12'(BY)); i++) step();
        origin_cyc = cyc;
    endtask

    task automatic wait_done_a(input string tag, input int bound);
        for (int i = 0; i < bound && !a_done_seen; i++) step();
        chk(tag, 32'(a_done_seen), 32'd1);
    endtask

    // Ideal count is d/2 at 2 clk/us; window widened by synchroniser plus debounce delay.
    task automatic push_window(input int d);
        exp_t e;
        e.lo = 16'(d / 2 - 1);
        e.hi = 16'((d + 2 + DEB + 1) / 2);
        e.to = 1'b0;
        qa.push_back(e);
    endtask

    task automatic start_a();
        wait_row(2);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
    endtask

    initial begin
        exp_t eb;
        reset_a = 1'b1;  reset_b = 1'b1;
        ifa.ce_pixel = 1'b1;  ifb.ce_pixel = 1'b1;
        ifa.start = 1'b0;  ifb.start = 1'b0;
        ifa.sensor = 1'b0; ifb.sensor = 1'b0;
        ifa.box_x = 12'(BX); ifa.box_y = 12'(BY); ifa.box_w = 12'(BW); ifa.box_h = 12'(BH);
        ifb.box_x = 12'(BX); ifb.box_y = 12'(BY); ifb.box_w = 12'(BW); ifb.box_h = 12'(BH);
        drive_raster(0, 0);
        repeat (3) step();
        reset_a = 1'b0;  reset_b = 1'b0;
        step();
        chk("rst_rgb", 32'(ifa.rgb), 32'h0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_result_us", 32'(ifa.result_us), 32'd0);
        chk("rst_timeout", 32'(ifa.timeout), 32'd0);

        // dut_b: sensor never high, runs to saturation in the background
        wait_row(2);
        eb.lo = 16'hFFFF;  eb.hi = 16'hFFFF;  eb.to = 1'b1;
        qb.push_back(eb);
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        step();
        chk("b_busy_started", 32'(ifb.busy), 32'd1);

        sweep_on = 1;  sweep_flash = 0;  bad_pix = 0;
        repeat (HT * VT) step();
        sweep_on = 0;
        chk("rgb_idle_sweep_bad", 32'(bad_pix), 32'd0);

        // normal measurement, light 100 clk after box origin
        start_a();
        step();
        chk("a_busy_arm", 32'(ifa.busy), 32'd1);
        wait_vs(1);
        wait_origin();
        repeat (100) step();
        a_done_seen = 0;
        push_window(cyc - origin_cyc);
        ifa.sensor = 1'b1;
        wait_done_a("a_done_normal", 200);
        ifa.sensor = 1'b0;
        sweep_on = 1;  sweep_flash = 0;  bad_pix = 0;
        wait_vs(7);
        sweep_on = 0;
        chk("rgb_cooldown_sweep_bad", 32'(bad_pix), 32'd0);
        repeat (5) step();
        chk("a_busy_after_7_vsync", 32'(ifa.busy), 32'd1);
        wait_vs(1);
        repeat (3) step();
        chk("a_busy_after_8_vsync", 32'(ifa.busy), 32'd0);

        // sensor already lit before start: result only once the timer starts, and it is 0
        ifa.sensor = 1'b1;
        start_a();
        wait_vs(1);
        wait_origin();
        a_done_seen = 0;
        eb.lo = 16'd0;  eb.hi = 16'd0;  eb.to = 1'b0;
        qa.push_back(eb);
        wait_done_a("a_done_stale_light", 10);
        ifa.sensor = 1'b0;
        wait_vs(8);
        repeat (3) step();
        chk("a_busy_after_stale", 32'(ifa.busy), 32'd0);

        // FLASH raster sweep, 3-clk glitch ignored, 4-clk pulse detected
        start_a();
        wait_vs(1);
        repeat (2) step();
        sweep_on = 1;  sweep_flash = 1;  bad_pix = 0;
        repeat (HT * VT) step();
        sweep_on = 0;
        chk("rgb_flash_sweep_bad", 32'(bad_pix), 32'd0);
        ifa.sensor = 1'b1;
        repeat (3) step();
        ifa.sensor = 1'b0;
        repeat (30) step();
        chk("a_busy_after_glitch", 32'(ifa.busy), 32'd1);
        a_done_seen = 0;
        push_window(cyc - last_origin);
        ifa.sensor = 1'b1;
        repeat (4) step();
        ifa.sensor = 1'b0;
        wait_done_a("a_done_pulse", 20);
        wait_vs(8);
        repeat (3) step();
        chk("a_busy_after_pulse", 32'(ifa.busy), 32'd0);

        // start re-pulsed in FLASH is ignored; reset mid-FLASH drops to IDLE without done
        start_a();
        wait_vs(1);
        repeat (3) step();
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        step();
        chk("a_busy_restart", 32'(ifa.busy), 32'd1);
        for (int i = 0; i < 2 * HT * VT && !(ifa.hcnt == 12'd12 && ifa.vcnt == 12'd12); i++) step();
        step();
        chk("rgb_flash_after_restart", 32'(ifa.rgb), 32'hFFFFFF);
        reset_a = 1'b1;
        step();
        chk("a_busy_after_reset", 32'(ifa.busy), 32'd0);
        chk("rgb_after_reset", 32'(ifa.rgb), 32'h0);
        reset_a = 1'b0;
        repeat (2 * HT * VT) step();
        chk("a_idle_post_reset", 32'(ifa.busy), 32'd0);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);

        for (int i = 0; i < 75000 && !b_done_seen; i++) step();
        chk("b_done_seen", 32'(b_done_seen), 32'd1);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
